// File: rtl/rr_phase_arbiter_pkg.sv
// Shared definitions for the three-requester round-robin phase arbiter.
//   state_t     : FSM encoding (IDLE/GRANT/GAP; 2'b11 is illegal)
//   NUM_REQ     : number of requesters
//   onehot3     : requester index -> one-hot grant vector
//   mod3_add    : index arithmetic that wraps at NUM_REQ
package rr_phase_arbiter_pkg;

  localparam int NUM_REQ = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_GRANT = 2'b01,
    ST_GAP   = 2'b10
  } state_t;

  function automatic logic [NUM_REQ-1:0] onehot3(input logic [1:0] idx);
    logic [NUM_REQ-1:0] v;
    v = '0;
    case (idx)
      2'd0:    v = 3'b001;
      2'd1:    v = 3'b010;
      2'd2:    v = 3'b100;
      default: v = 3'b000;
    endcase
    return v;
  endfunction

  // Sum of two indices modulo 3; result is always 0..2.
  function automatic logic [1:0] mod3_add(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 3'd3) s = s - 3'd3;
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational round-robin winner selection for three requesters.
//   req    : request vector
//   ptr    : highest-priority index (search order ptr, ptr+1, ptr+2 mod 3)
//   winner : first set request in search order (0 when none)
//   any    : at least one request is set
module rr_pick3
  import rr_phase_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         ptr,
  output logic [1:0]         winner,
  output logic               any
);

  logic       found;
  logic [1:0] idx;

  always_comb begin
    winner = 2'd0;
    found  = 1'b0;
    idx    = 2'd0;
    any    = |req;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = mod3_add(ptr, 2'(i));
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_phase_arbiter.sv
// Round-robin arbiter with a Moore IDLE/GRANT/GAP sequencer per grant.
// An owner keeps the resource while its request stays high, up to MAX_HOLD
// cycles; every grant is followed by one GAP cycle with no owner.
//   clk         : rising-edge clock
//   reset_n     : asynchronous active-low reset
//   en          : arbitration enable (gates new grants only)
//   req         : level-sensitive requests
//   grant       : registered one-hot grant
//   grant_id    : index of current owner (0 when none)
//   grant_valid : grant is non-zero
//   timeout     : one-cycle pulse in the GAP after a forced revocation
//   arb_state   : current FSM state
module rr_phase_arbiter
  import rr_phase_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [1:0]         grant_id,
  output logic               grant_valid,
  output logic               timeout,
  output logic [1:0]         arb_state
);

  localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD);

  state_t           state;
  logic [1:0]       ptr;
  logic [CNT_W-1:0] hold_cnt;
  logic [1:0]       winner;
  logic             any;
  logic             owner_req;

  rr_pick3 u_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (winner),
    .any    (any)
  );

  // grant is one-hot on the owner, so this picks out the owner's request.
  assign owner_req = |(req & grant);
  assign arb_state = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      grant       <= '0;
      grant_id    <= 2'd0;
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
      ptr         <= 2'd0;
      hold_cnt    <= '0;
    end else begin
      case (state)
        // GAP arbitrates exactly like IDLE, with the ptr advanced on exit
        // from GRANT.
        ST_IDLE, ST_GAP: begin
          timeout <= 1'b0;
          if (en && any) begin
            state       <= ST_GRANT;
            grant       <= onehot3(winner);
            grant_id    <= winner;
            grant_valid <= 1'b1;
            hold_cnt    <= CNT_W'(1);
          end else begin
            state       <= ST_IDLE;
            grant       <= '0;
            grant_id    <= 2'd0;
            grant_valid <= 1'b0;
            hold_cnt    <= '0;
          end
        end
        ST_GRANT: begin
          if (!owner_req || hold_cnt == HOLD_LIMIT) begin
            state       <= ST_GAP;
            // Only a revocation with the request still high is a timeout.
            timeout     <= owner_req;
            ptr         <= mod3_add(grant_id, 2'd1);
            grant       <= '0;
            grant_id    <= 2'd0;
            grant_valid <= 1'b0;
            hold_cnt    <= '0;
          end else begin
            hold_cnt    <= hold_cnt + CNT_W'(1);
          end
        end
        default: begin
          state       <= ST_IDLE;
          grant       <= '0;
          grant_id    <= 2'd0;
          grant_valid <= 1'b0;
          timeout     <= 1'b0;
          hold_cnt    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_phase_arbiter.sv
module tb_rr_phase_arbiter;

  logic       clk;
  logic       reset_n;
  logic       en;
  logic [2:0] req;

  logic [2:0] g4, g2, g1;
  logic [1:0] id4, id2, id1;
  logic [1:0] st4, st2, st1;
  logic       v4, v2, v1;
  logic       to4, to2, to1;

  int total = 0;
  int bad   = 0;

  rr_phase_arbiter #(.MAX_HOLD(4), .CNT_W(4)) u_h4 (
    .clk(clk), .reset_n(reset_n), .en(en), .req(req),
    .grant(g4), .grant_id(id4), .grant_valid(v4), .timeout(to4), .arb_state(st4)
  );

  rr_phase_arbiter #(.MAX_HOLD(2), .CNT_W(4)) u_h2 (
    .clk(clk), .reset_n(reset_n), .en(en), .req(req),
    .grant(g2), .grant_id(id2), .grant_valid(v2), .timeout(to2), .arb_state(st2)
  );

  rr_phase_arbiter #(.MAX_HOLD(1), .CNT_W(4)) u_h1 (
    .clk(clk), .reset_n(reset_n), .en(en), .req(req),
    .grant(g1), .grant_id(id1), .grant_valid(v1), .timeout(to1), .arb_state(st1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    en      = 1'b0;
    req     = 3'b000;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    en      = 1'b1;
    req     = 3'b111;
    @(negedge clk);
    total++; if (g4 !== 3'b000) begin bad++; $display("FAIL reset_grant: got %b want 000", g4); end
    total++; if (id4 !== 2'd0) begin bad++; $display("FAIL reset_id: got %0d want 0", id4); end
    total++; if (v4 !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", v4); end
    total++; if (to4 !== 1'b0) begin bad++; $display("FAIL reset_timeout: got %b want 0", to4); end
    total++; if (st4 !== 2'b00) begin bad++; $display("FAIL reset_state: got %b want 00", st4); end
    reset_n = 1'b1;
    #1;
    total++; if (g4 !== 3'b000) begin bad++; $display("FAIL release_no_edge_grant: got %b want 000", g4); end
    @(posedge clk);
    #1;
    total++; if (g4 !== 3'b001) begin bad++; $display("FAIL first_grant: got %b want 001", g4); end
    total++; if (v4 !== 1'b1) begin bad++; $display("FAIL first_valid: got %b want 1", v4); end
    total++; if (id4 !== 2'd0) begin bad++; $display("FAIL first_id: got %0d want 0", id4); end
    total++; if (st4 !== 2'b01) begin bad++; $display("FAIL first_state: got %b want 01", st4); end
    @(negedge clk);
  endtask

  task automatic test_single();
    do_reset();
    en  = 1'b1;
    req = 3'b010;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (g4 !== 3'b010) begin bad++; $display("FAIL single_grant[%0d]: got %b want 010", i, g4); end
      total++; if (id4 !== 2'd1) begin bad++; $display("FAIL single_id[%0d]: got %0d want 1", i, id4); end
      total++; if (to4 !== 1'b0) begin bad++; $display("FAIL single_timeout[%0d]: got %b want 0", i, to4); end
    end
    req = 3'b000;
    tick();
    total++; if (st4 !== 2'b10) begin bad++; $display("FAIL single_gap_state: got %b want 10", st4); end
    total++; if (g4 !== 3'b000) begin bad++; $display("FAIL single_gap_grant: got %b want 000", g4); end
    total++; if (to4 !== 1'b0) begin bad++; $display("FAIL single_gap_timeout: got %b want 0", to4); end
    tick();
    total++; if (st4 !== 2'b00) begin bad++; $display("FAIL single_idle_state: got %b want 00", st4); end
    // ptr should now be 2: with everyone requesting, requester 2 wins.
    req = 3'b111;
    tick();
    total++; if (g4 !== 3'b100) begin bad++; $display("FAIL single_ptr_grant: got %b want 100", g4); end
    total++; if (id4 !== 2'd2) begin bad++; $display("FAIL single_ptr_id: got %0d want 2", id4); end
  endtask

  task automatic test_round_robin();
    logic [2:0] eg2 [10];
    logic       et2 [10];
    logic [2:0] eg1 [10];
    logic       et1 [10];
    logic [1:0] ei;
    logic [1:0] es;
    eg2 = '{3'b001, 3'b001, 3'b000, 3'b010, 3'b010, 3'b000, 3'b100, 3'b100, 3'b000, 3'b001};
    et2 = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    eg1 = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001, 3'b000, 3'b010, 3'b000};
    et1 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    en  = 1'b1;
    req = 3'b111;
    for (int i = 0; i < 10; i++) begin
      tick();
      ei = (eg2[i] == 3'b100) ? 2'd2 : (eg2[i] == 3'b010) ? 2'd1 : 2'd0;
      es = (eg2[i] == 3'b000) ? 2'b10 : 2'b01;
      total++; if (g2 !== eg2[i]) begin bad++; $display("FAIL rr2_grant[%0d]: got %b want %b", i, g2, eg2[i]); end
      total++; if (to2 !== et2[i]) begin bad++; $display("FAIL rr2_timeout[%0d]: got %b want %b", i, to2, et2[i]); end
      total++; if (id2 !== ei) begin bad++; $display("FAIL rr2_id[%0d]: got %0d want %0d", i, id2, ei); end
      total++; if (v2 !== (eg2[i] != 3'b000)) begin bad++; $display("FAIL rr2_valid[%0d]: got %b", i, v2); end
      total++; if (st2 !== es) begin bad++; $display("FAIL rr2_state[%0d]: got %b want %b", i, st2, es); end
      ei = (eg1[i] == 3'b100) ? 2'd2 : (eg1[i] == 3'b010) ? 2'd1 : 2'd0;
      es = (eg1[i] == 3'b000) ? 2'b10 : 2'b01;
      total++; if (g1 !== eg1[i]) begin bad++; $display("FAIL rr1_grant[%0d]: got %b want %b", i, g1, eg1[i]); end
      total++; if (to1 !== et1[i]) begin bad++; $display("FAIL rr1_timeout[%0d]: got %b want %b", i, to1, et1[i]); end
      total++; if (id1 !== ei) begin bad++; $display("FAIL rr1_id[%0d]: got %0d want %0d", i, id1, ei); end
      total++; if (v1 !== (eg1[i] != 3'b000)) begin bad++; $display("FAIL rr1_valid[%0d]: got %b", i, v1); end
      total++; if (st1 !== es) begin bad++; $display("FAIL rr1_state[%0d]: got %b want %b", i, st1, es); end
    end
  endtask

  task automatic test_timeout();
    logic [2:0] eg [6];
    logic       et [6];
    logic [1:0] es [6];
    eg = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b000, 3'b001};
    et = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    es = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01};
    do_reset();
    en  = 1'b1;
    req = 3'b001;
    for (int i = 0; i < 6; i++) begin
      tick();
      total++; if (g4 !== eg[i]) begin bad++; $display("FAIL to_grant[%0d]: got %b want %b", i, g4, eg[i]); end
      total++; if (to4 !== et[i]) begin bad++; $display("FAIL to_timeout[%0d]: got %b want %b", i, to4, et[i]); end
      total++; if (st4 !== es[i]) begin bad++; $display("FAIL to_state[%0d]: got %b want %b", i, st4, es[i]); end
    end
  endtask

  task automatic test_enable();
    do_reset();
    en  = 1'b0;
    req = 3'b100;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if (st4 !== 2'b00) begin bad++; $display("FAIL en_off_state[%0d]: got %b want 00", i, st4); end
      total++; if (g4 !== 3'b000) begin bad++; $display("FAIL en_off_grant[%0d]: got %b want 000", i, g4); end
    end
    en = 1'b1;
    tick();
    total++; if (g4 !== 3'b100) begin bad++; $display("FAIL en_on_grant: got %b want 100", g4); end
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (g4 !== 3'b100) begin bad++; $display("FAIL en_drop_hold[%0d]: got %b want 100", i, g4); end
    end
    req = 3'b000;
    tick();
    total++; if (st4 !== 2'b10) begin bad++; $display("FAIL en_release_state: got %b want 10", st4); end
    total++; if (to4 !== 1'b0) begin bad++; $display("FAIL en_release_timeout: got %b want 0", to4); end
    req = 3'b100;
    tick();
    total++; if (st4 !== 2'b00) begin bad++; $display("FAIL en_gap_to_idle: got %b want 00", st4); end
    tick();
    total++; if (g4 !== 3'b000) begin bad++; $display("FAIL en_idle_hold: got %b want 000", g4); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    en  = 1'b1;
    req = 3'b011;
    tick();
    total++; if (g4 !== 3'b001) begin bad++; $display("FAIL b2b_first: got %b want 001", g4); end
    req = 3'b010;
    tick();
    total++; if (st4 !== 2'b10) begin bad++; $display("FAIL b2b_gap: got %b want 10", st4); end
    total++; if (to4 !== 1'b0) begin bad++; $display("FAIL b2b_gap_timeout: got %b want 0", to4); end
    tick();
    total++; if (g4 !== 3'b010) begin bad++; $display("FAIL b2b_second: got %b want 010", g4); end
    total++; if (id4 !== 2'd1) begin bad++; $display("FAIL b2b_second_id: got %0d want 1", id4); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    en  = 1'b1;
    req = 3'b001;
    tick();
    req = 3'b000;
    tick();
    req = 3'b010;
    tick();
    total++; if (g4 !== 3'b010) begin bad++; $display("FAIL mid_pre_grant: got %b want 010", g4); end
    #2;
    reset_n = 1'b0;
    #1;
    total++; if (g4 !== 3'b000) begin bad++; $display("FAIL mid_async_grant: got %b want 000", g4); end
    total++; if (v4 !== 1'b0) begin bad++; $display("FAIL mid_async_valid: got %b want 0", v4); end
    total++; if (st4 !== 2'b00) begin bad++; $display("FAIL mid_async_state: got %b want 00", st4); end
    total++; if (id4 !== 2'd0) begin bad++; $display("FAIL mid_async_id: got %0d want 0", id4); end
    @(negedge clk);
    reset_n = 1'b1;
    req     = 3'b111;
    tick();
    total++; if (g4 !== 3'b001) begin bad++; $display("FAIL mid_ptr_cleared: got %b want 001", g4); end
  endtask

  initial begin
    reset_n = 1'b0;
    en      = 1'b0;
    req     = 3'b000;
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_enable();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
